// File: rtl/rr_mux_8to1_pkg.sv
// Shared constants, FSM state type and one-hot decode helper for the
// eight-channel round-robin collector.
package mux_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_mux_8to1_if.sv
// Producer/consumer bundle of the 8:1 collector; master is the
// environment (producers + consumer), slave is the mux itself.
interface rr_mux_8to1_if
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [NUM_CH*WIDTH-1:0] din;
  logic [NUM_CH-1:0]       din_valid;
  logic [NUM_CH-1:0]       din_ready;
  logic [WIDTH-1:0]        dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic [SEL_W-1:0]        sel;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, sel
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, sel
  );

endinterface

// File: rtl/rr_mux_8to1_arbiter.sv
// Combinational rotate-priority-rotate arbiter: the first requester after
// channel `last` (wrapping 7->0) wins when `en` is high.
module rr_arbiter_8
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

  logic [SEL_W-1:0]  start;
  logic [NUM_CH-1:0] rot;
  logic [NUM_CH-1:0] pri;

  always_comb begin
    start = last + SEL_W'(1);
    rot   = '0;
    gnt   = '0;
    // 3-bit index arithmetic wraps modulo 8, giving the rotation for free
    for (int i = 0; i < NUM_CH; i++) begin
      rot[i] = req[SEL_W'(i) + start];
    end
    pri = rot & (~rot + NUM_CH'(1));
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[SEL_W'(i) + start] = pri[i] & en;
    end
    gnt_idx = onehot_to_idx(gnt);
    any     = |req;
  end

endmodule

// File: rtl/rr_mux_8to1.sv
// Merges eight valid/ready producers onto one registered output with
// round-robin fairness; sel tags each word with its source channel.
module rr_mux_8to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_mux_8to1_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any;
  logic              load_en;
  logic [NUM_CH-1:0] din_ready_c;

  // Output register can take a new word when empty or being drained this cycle
  assign load_en = (state_q == EMPTY) | bus.dout_ready;

  rr_arbiter_8 u_arb (
    .req     (bus.din_valid),
    .last    (last_q),
    .en      (load_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      dout_q  <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    sel_d       = sel_q;
    last_d      = last_q;
    din_ready_c = '0;

    case (state_q)
      EMPTY: begin
        if (any) state_d = FULL;
      end
      FULL: begin
        if (bus.dout_ready && !any) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    // Accepting a word also advances the round-robin pointer
    if (load_en && any) begin
      din_ready_c = gnt;
      dout_d      = bus.din[gnt_idx*WIDTH +: WIDTH];
      sel_d       = gnt_idx;
      last_d      = gnt_idx;
    end
  end

  assign bus.din_ready  = din_ready_c;
  assign bus.dout       = dout_q;
  assign bus.sel        = sel_q;
  assign bus.dout_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux_8to1.sv
// Directed bench for rr_mux_8to1: stimulus pushes expected words into a
// scoreboard queue, an independent monitor pops them on each output transfer.
module tb_rr_mux_8to1;
  import mux_pkg::*;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_mux_8to1_if #(.WIDTH(WIDTH)) bus ();

  rr_mux_8to1 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  int   n_exp = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [WIDTH-1:0] chd [NUM_CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flush_sb();
    n_exp = n_exp - sbq.size();
    sbq.delete();
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, return at next posedge+1
  task automatic step(input logic [7:0] v, input logic rdy,
                      input logic [7:0] exp_rdy, input logic exp_vld);
    exp_t e;
    bus.din_valid  = v;
    bus.dout_ready = rdy;
    for (int i = 0; i < NUM_CH; i++) bus.din[i*WIDTH +: WIDTH] = chd[i];
    @(negedge clk);
    check("din_ready", 64'(bus.din_ready), 64'(exp_rdy));
    check("dout_valid", 64'(bus.dout_valid), 64'(exp_vld));
    for (int i = 0; i < NUM_CH; i++) begin
      if (exp_rdy[i]) begin
        e.data = chd[i];
        e.sel  = SEL_W'(i);
        sbq.push_back(e);
        n_exp++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.din_valid  = '0;
    bus.dout_ready = 1'b0;
    flush_sb();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every output transfer must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
      n_out++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got dout=0x%0h sel=%0d, expected no word", bus.dout, bus.sel);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_dout", 64'(bus.dout), 64'(mon_e.data));
        check("sb_sel", 64'(bus.sel), 64'(mon_e.sel));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = '0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) chd[i] = '0;

    // Reset then idle
    repeat (2) begin
      @(negedge clk);
      check("rst_dout", 64'(bus.dout), 64'h0);
      check("rst_vld", 64'(bus.dout_valid), 64'h0);
      check("rst_sel", 64'(bus.sel), 64'h0);
      check("rst_ready", 64'(bus.din_ready), 64'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(8'h00, 1'b1, 8'h00, 1'b0);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    check("idle_dout", 64'(bus.dout), 64'h0);
    check("idle_sel", 64'(bus.sel), 64'h0);

    // Single channel streaming, no bubbles
    for (int k = 0; k < 4; k++) begin
      chd[2] = 8'hA0 + 8'(k);
      step(8'h04, 1'b1, 8'h04, k != 0);
    end
    step(8'h00, 1'b1, 8'h00, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b0);

    // Full contention from a fresh pointer: 0..7,0,1
    do_reset();
    for (int i = 0; i < NUM_CH; i++) chd[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 10; k++) begin
      step(8'hFF, 1'b1, 8'(1 << (k % 8)), k != 0);
    end
    step(8'h00, 1'b1, 8'h00, 1'b1);

    // Backpressure: 5 held for three cycles, then 6 before 1
    chd[5] = 8'h55;
    chd[6] = 8'h66;
    chd[1] = 8'h11;
    step(8'h20, 1'b1, 8'h20, 1'b0);
    repeat (3) begin
      step(8'h42, 1'b0, 8'h00, 1'b1);
      check("stall_dout", 64'(bus.dout), 64'h55);
      check("stall_sel", 64'(bus.sel), 64'd5);
    end
    step(8'h42, 1'b1, 8'h40, 1'b1);
    step(8'h02, 1'b1, 8'h02, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b0);

    // Wrap-around: after 7, channel 0 beats 6; last=3 with only 2 grants 2
    chd[7] = 8'h77;
    chd[0] = 8'hF0;
    step(8'h80, 1'b1, 8'h80, 1'b0);
    step(8'h41, 1'b1, 8'h01, 1'b1);
    step(8'h41, 1'b1, 8'h40, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    chd[3] = 8'h33;
    chd[2] = 8'h22;
    step(8'h08, 1'b1, 8'h08, 1'b0);
    step(8'h04, 1'b1, 8'h04, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b0);

    // Asynchronous reset while holding a word from channel 4
    chd[4] = 8'h44;
    step(8'h10, 1'b1, 8'h10, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b1);
    check("pre_rst_sel", 64'(bus.sel), 64'd4);
    #2;
    rst_n = 1'b0;
    flush_sb();
    #1;
    check("arst_vld", 64'(bus.dout_valid), 64'h0);
    check("arst_sel", 64'(bus.sel), 64'h0);
    check("arst_dout", 64'(bus.dout), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NUM_CH; i++) chd[i] = 8'hC0 + 8'(i);
    step(8'hFF, 1'b1, 8'h01, 1'b0);
    step(8'hFF, 1'b1, 8'h02, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b0);

    check("sb_drained", 64'(sbq.size()), 64'h0);
    check("out_count", 64'(n_out), 64'(n_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
